// File: rtl/ram_master.sv
// ram_master
//    Bus initiator for a pin-level RAM model. Turns valid/ready read and write
//    requests into RAM cycles on address/data/we. Owns the shared inout data
//    bus: drives it only while a write is in ACCESS or HOLD, tri-states it
//    otherwise.
//
// Parameters
//    awidth       address width of the attached RAM
//    dwidth       data width of the attached RAM
//    WAIT_STATES  extra ACCESS cycles per transfer (0..15)
//
// Ports
//    clk        clock, rising edge
//    reset_n    asynchronous active-low reset
//    req_valid  request present
//    req_ready  request can be accepted (IDLE only)
//    req_we     1 = write, 0 = read
//    req_addr   request address
//    req_wdata  write data
//    rsp_valid  one-cycle pulse, rsp_rdata valid (reads only)
//    rsp_rdata  read data, held until the next read completes
//    address    RAM address, holds its last value while idle
//    data       RAM data bus (inout)
//    we         RAM write enable
//
// Build option
//    RAM_MASTER_STATS_EN  adds rd_count[15:0] / wr_count[15:0] accept counters
//
// state  | meaning
// IDLE   | ready for a request, bus released
// ACCESS | address presented for WAIT_STATES+1 cycles; we/data active on writes
// HOLD   | write only: we dropped, data and address held one more cycle

module ram_master #(
    parameter int awidth      = 8,
    parameter int dwidth      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [awidth-1:0] req_addr,
    input  logic [dwidth-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [dwidth-1:0] rsp_rdata,
    output logic [awidth-1:0] address,
    inout  wire  [dwidth-1:0] data,
    output logic              we
`ifdef RAM_MASTER_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t              state_q;
    state_t              state_d;
    logic                ready_en_q;
    logic [awidth-1:0]   addr_q;
    logic [dwidth-1:0]   wdata_q;
    logic                wr_q;
    logic [3:0]          cnt_q;
    logic                rsp_valid_q;
    logic [dwidth-1:0]   rsp_rdata_q;

    logic                accept;
    logic                last_access;
    logic                drive_en;

    // ready_en_q keeps req_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    // Bus controls decode straight from the state register so an async reset
    // releases data and drops we in the same cycle.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        last_access = 1'b0;
        req_ready   = 1'b0;
        we          = 1'b0;
        drive_en    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = ready_en_q;
                if (req_valid && ready_en_q) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                we       = wr_q;
                drive_en = wr_q;
                if (cnt_q == 4'd0) begin
                    last_access = 1'b1;
                    state_d     = wr_q ? HOLD : IDLE;
                end
            end
            HOLD: begin
                drive_en = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data = drive_en ? wdata_q : {dwidth{1'bz}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wr_q    <= req_we;
                cnt_q   <= WAIT_LOAD;
            end else if (state_q == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // read data is captured on the final ACCESS edge
            if (last_access && !wr_q) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= data;
            end
        end
    end

    assign address   = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef RAM_MASTER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (accept) begin
            if (req_we) begin
                wr_count <= wr_count + 16'd1;
            end else begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_master.sv
module tb_ram_master;

    localparam int W = 1;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance (WAIT_STATES = W) with a RAM model on its bus
    logic       req_valid, req_we, req_ready, rsp_valid, we;
    logic [7:0] req_addr, req_wdata, rsp_rdata, address;
    wire  [7:0] data;
    pullup (data);

    // two timing-only instances (WAIT_STATES 0 and 15), no RAM attached
    logic [1:0] t_valid, t_we_in, t_ready, t_rsp, t_wes;
    logic [7:0] t_addr, t_wdata, t_rdata0, t_rdata1, t_address0, t_address1;
    wire  [7:0] t_data0, t_data1;
    pullup (t_data0);
    pullup (t_data1);

`ifdef RAM_MASTER_STATS_EN
    logic [15:0] rd_count, wr_count, s_rd0, s_wr0, s_rd1, s_wr1;
`endif

    ram_master #(.awidth(8), .dwidth(8), .WAIT_STATES(W)) u_main (
        .clk(clk), .reset_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .address(address),
        .data(data), .we(we)
`ifdef RAM_MASTER_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    ram_master #(.awidth(8), .dwidth(8), .WAIT_STATES(0)) u_w0 (
        .clk(clk), .reset_n(rst_n), .req_valid(t_valid[0]), .req_ready(t_ready[0]),
        .req_we(t_we_in[0]), .req_addr(t_addr), .req_wdata(t_wdata),
        .rsp_valid(t_rsp[0]), .rsp_rdata(t_rdata0), .address(t_address0),
        .data(t_data0), .we(t_wes[0])
`ifdef RAM_MASTER_STATS_EN
        , .rd_count(s_rd0), .wr_count(s_wr0)
`endif
    );

    ram_master #(.awidth(8), .dwidth(8), .WAIT_STATES(15)) u_w15 (
        .clk(clk), .reset_n(rst_n), .req_valid(t_valid[1]), .req_ready(t_ready[1]),
        .req_we(t_we_in[1]), .req_addr(t_addr), .req_wdata(t_wdata),
        .rsp_valid(t_rsp[1]), .rsp_rdata(t_rdata1), .address(t_address1),
        .data(t_data1), .we(t_wes[1])
`ifdef RAM_MASTER_STATS_EN
        , .rd_count(s_rd1), .wr_count(s_wr1)
`endif
    );

    // RAM model: stores on we edges, drives the bus only while a read is open
    logic [7:0] mem [256] = '{default: 8'h00};
    bit         rd_window = 1'b0;
    wire        ram_oe = rst_n && !we && rd_window;
    assign data = ram_oe ? mem[address] : 8'bz;
    always @(posedge clk) if (rst_n && we) mem[address] <= data;

    // reference model and scoreboard
    typedef struct {
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] r;
        logic [7:0] old;
        int         acc;
    } txn_t;

    logic [7:0] ref_mem [256] = '{default: 8'h00};
    txn_t       exp_q[$];
    txn_t       cur;
    bit         in_wr = 1'b0;
    bit         we_d = 1'b0;
    int         hold_cyc = -1;
    int         rsp_seen = 0;
    int         rd_acc = 0;
    int         wr_acc = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_rdata = 8'h00;

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        bad++;
        $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) fail(name, act, req);
        else total++;
    endtask

    always @(negedge clk) begin
        txn_t e;
        if (!rst_n) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_back();
                if (e.w) ref_mem[e.a] = e.old;
            end
            if (in_wr) ref_mem[cur.a] = cur.old;
            in_wr      = 1'b0;
            hold_cyc   = -1;
            we_d       = 1'b0;
            rd_window  = 1'b0;
            last_addr  = 8'h00;
            last_rdata = 8'h00;
            rd_acc     = 0;
            wr_acc     = 0;
        end else begin
            if (!in_wr && !rd_window && exp_q.size() == 0) begin
                chk("idle_ready", req_ready, 1);
                chk("idle_we", we, 0);
                chk("idle_data_released", data, 8'hFF);
                chk("idle_addr_held", address, last_addr);
            end
            if (rd_window && !rsp_valid) begin
                chk("read_busy_ready", req_ready, 0);
                chk("read_we_low", we, 0);
            end
            if (rsp_valid) begin
                rsp_seen++;
                if (exp_q.size() == 0 || exp_q[0].w) begin
                    fail("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.r);
                    chk("rsp_cycle", cyc, e.acc + W + 2);
                    last_rdata = e.r;
                    rd_window  = 1'b0;
                end
            end else begin
                chk("rsp_rdata_hold", rsp_rdata, last_rdata);
            end
            if (we && !we_d) begin
                if (exp_q.size() == 0 || !exp_q[0].w) begin
                    fail("we_unexpected", we, 0);
                end else begin
                    cur      = exp_q.pop_front();
                    in_wr    = 1'b1;
                    hold_cyc = cur.acc + W + 2;
                    chk("we_rise_cycle", cyc, cur.acc + 1);
                end
            end
            if (we) begin
                chk("wr_addr", address, cur.a);
                chk("wr_data", data, cur.d);
                chk("wr_busy_ready", req_ready, 0);
            end
            if (in_wr && cyc == hold_cyc) begin
                chk("hold_we", we, 0);
                chk("hold_data", data, cur.d);
                chk("hold_addr", address, cur.a);
                in_wr = 1'b0;
            end
            if (req_valid && req_ready) begin
                e.w   = req_we;
                e.a   = req_addr;
                e.d   = req_wdata;
                e.old = ref_mem[req_addr];
                e.r   = ref_mem[req_addr];
                e.acc = cyc;
                if (req_we) begin
                    ref_mem[req_addr] = req_wdata;
                    wr_acc++;
                end else begin
                    rd_window = 1'b1;
                    rd_acc++;
                end
                exp_q.push_back(e);
                last_addr = req_addr;
            end
            we_d = we;
        end
    end

    // stimulus
    bit prev_keep = 1'b0;
    bit prev_w    = 1'b0;
    int prev_acc  = 0;

    task automatic align();
        if (($time % 10) != 6) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] d, input bit keep);
        int n = 0;
        align();
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 60);
        if (!req_ready) begin
            fail("accept_timeout", n, 60);
            req_valid = 1'b0;
            prev_keep = 1'b0;
            return;
        end
        if (prev_keep) chk("b2b_accept_gap", cyc - prev_acc, prev_w ? W + 3 : W + 2);
        prev_keep = keep;
        prev_w    = w;
        prev_acc  = cyc;
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_wr || rd_window) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("drain_timeout", n, 100);
        @(negedge clk);
    endtask

    task automatic tmg(input int k, input int w);
        int         n;
        bit         seen;
        logic [7:0] dv;
        logic [7:0] av;
        align();
        t_addr     = 8'h20 + 8'(k);
        t_wdata    = 8'h3C;
        t_we_in[k] = 1'b1;
        t_valid[k] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!t_ready[k] && n < 10);
        @(posedge clk);
        #1;
        t_valid[k] = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (t_wes[k]) seen = 1'b1;
            else if (seen) break;
        end
        dv = (k == 0) ? t_data0 : t_data1;
        av = (k == 0) ? t_address0 : t_address1;
        chk($sformatf("w%0d_hold_cycle", w), n, w + 2);
        chk($sformatf("w%0d_hold_data", w), dv, 8'h3C);
        chk($sformatf("w%0d_hold_addr", w), av, 8'h20 + 8'(k));
        t_we_in[k] = 1'b0;
        t_valid[k] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!t_ready[k] && n < 10);
        @(posedge clk);
        #1;
        t_valid[k] = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (t_rsp[k]) break;
        end
        chk($sformatf("w%0d_rsp_cycle", w), n, w + 2);
        dv = (k == 0) ? t_rdata0 : t_rdata1;
        chk($sformatf("w%0d_read_bus_released", w), dv, 8'hFF);
    endtask

    initial begin
        int n0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        t_valid   = 2'b00;
        t_we_in   = 2'b00;
        t_addr    = 8'h00;
        t_wdata   = 8'h00;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_we", we, 0);
        chk("rst_data", data, 8'hFF);
        chk("rst_address", address, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_release", req_ready, 1);

        issue(1'b1, 8'h10, 8'h5A, 1'b0);
        drain();
        issue(1'b0, 8'h10, 8'h00, 1'b0);
        drain();
        chk("directed_rdata", rsp_rdata, 8'h5A);

        n0 = rsp_seen;
        issue(1'b1, 8'h21, 8'hC3, 1'b1);
        issue(1'b0, 8'h21, 8'h00, 1'b1);
        issue(1'b1, 8'h22, 8'h3C, 1'b1);
        issue(1'b0, 8'h22, 8'h00, 1'b0);
        drain();
        chk("b2b_rsp_pulses", rsp_seen - n0, 2);

        for (int i = 0; i < 80; i++) begin
            bit keep;
            keep = (i < 79) ? 1'($urandom_range(0, 1)) : 1'b0;
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), keep);
            if (!keep) repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        issue(1'b1, 8'h05, 8'hE7, 1'b0);
        #1 chk("pre_reset_we", we, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_we", we, 0);
        chk("midreset_data", data, 8'hFF);
        repeat (3) begin
            @(negedge clk);
            chk("midreset_no_rsp", rsp_valid, 0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_midreset", req_ready, 1);
        issue(1'b0, 8'h05, 8'h00, 1'b0);
        drain();

        tmg(0, 0);
        tmg(1, 15);

`ifdef RAM_MASTER_STATS_EN
        chk("rd_count", rd_count, rd_acc);
        chk("wr_count", wr_count, wr_acc);
`endif
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        fail("watchdog", cyc, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
